dpram_be: RTL and testbench
===========================

// Module: dpram_be
// PURPOSE
// - Simple dual-port block RAM, next generation: port A write-only with byte enables, port B read-only.
// - Adds configurable read latency, a selectable read-during-write collision mode and a post-reset
//   hardware clear sweep with a busy flag.
// - Used as the generic storage primitive for core buffers: register file shadow, queues and caches.
// PARAMETERS
// - WIDTH    32    data width in bits; must be a multiple of 8 (elaboration error otherwise)
// - DEPTH    1024  number of words; any value >= 2, need not be a power of two
// - RD_LAT   1     read latency in cycles; legal values 1 (array read) or 2 (extra output register)
// - FWD_MODE 0     0 = read-old on same-address collision; 1 = write-first (forward new bytes)
// - INIT_CLR 1     1 = zero every word after reset; 0 = no sweep, ready immediately after reset
// PORTS
// - clk        in   1              rising-edge clock
// - rst        in   1              synchronous, active-high reset
// - init_busy  out  1              1 while the clear sweep runs; all requests are ignored
// - wen        in   1              write strobe, port A
// - wbe        in   WIDTH/8        byte enables; bit i covers dina[8i+7:8i]
// - addra      in   clog2(DEPTH)   write address
// - dina       in   WIDTH          write data
// - ren        in   1              read strobe, port B
// - addrb      in   clog2(DEPTH)   read address
// - doutb      out  WIDTH          read data; held until the next accepted read completes
// - doutb_vld  out  1              1-cycle pulse marking doutb updated by an accepted read
// BEHAVIOUR
// - Reset values: doutb = 0, doutb_vld = 0, pipeline valid bits = 0.
// - init_busy = INIT_CLR during and directly after reset.
// - Clear FSM: IDLE -> CLEAR on rst (when INIT_CLR = 1).
//   - CLEAR writes 0 to word clr_cnt, then increments clr_cnt; clr_cnt starts at 0.
//   - CLEAR -> READY after writing word DEPTH-1, so init_busy is high for exactly DEPTH cycles
//     after rst deasserts.
//   - READY is absorbing until the next rst.
// - Reset mid-sweep or mid-read: clr_cnt returns to 0, the sweep restarts and in-flight reads are
//   dropped (no vld pulse).
// - While init_busy = 1: wen and ren are ignored and doutb_vld stays 0.
// - Write: on a clk edge with wen = 1, mem[addra] byte i <= dina byte i for every i with wbe[i] = 1.
//   wen with wbe = 0 leaves memory unchanged.
// - Read: ren = 1 at edge t.
//   - RD_LAT = 1: doutb and doutb_vld = 1 valid after edge t.
//   - RD_LAT = 2: valid after edge t+1.
//   - Back-to-back reads give one result per cycle, in order.
// - Collision (wen & ren, addra == addrb, same edge):
//   - FWD_MODE = 0: doutb returns the pre-write word.
//   - FWD_MODE = 1: doutb returns the merged word: enabled bytes from dina, others from the old word.
// - No forwarding from a write on a later edge into an already-issued read when RD_LAT = 2.
//   The result reflects memory at edge t.
// - Out-of-range address (>= DEPTH, non-power-of-two DEPTH only):
//   - write is dropped;
//   - read returns 0 with doutb_vld = 1.
// - When ren = 0, doutb holds its last value and doutb_vld = 0.
// STRUCTURE
// - Shared package core_mem_pkg:
//   - constant function clog2 (the same ceil-log2 used by all memory blocks);
//   - localparams FWD_READ_OLD = 0 and FWD_WRITE_FIRST = 1;
//   - enum for clear-FSM states IDLE/CLEAR/READY.
// - One sub-module, dpram_clr_seq: clear FSM and counter.
//   - Outputs clr_wen, clr_addr and init_busy.
//   - The top muxes these onto the port-A write path.
// - Storage array: inferred as a single reg array, byte writes via a per-byte loop.
// TESTING
// - Reset sweep: WIDTH=32, DEPTH=16, INIT_CLR=1.
//   - rst for 2 cycles -> init_busy high exactly 16 cycles.
//   - A read of every address afterwards returns 0x00000000.
// - Byte enables:
//   - write 0xAABBCCDD to addr 3 with wbe=4'hF, then 0x11223344 with wbe=4'b0101;
//   - read addr 3 -> 0xAA22CC44.
// - Latency: RD_LAT=2, reads of addr 1,2,3 on consecutive edges.
//   - doutb_vld high 2 cycles later for 3 cycles, data in order.
// - Collision: mem[5]=0x00000000, wen+ren at addr 5, dina=0xFFFFFFFF, wbe=4'b0011.
//   - FWD_MODE=0 returns 0x00000000.
//   - FWD_MODE=1 returns 0x0000FFFF.
// - Busy/reset: assert rst while the sweep is at word 7 and a read is in flight.
//   - No doutb_vld pulse; the sweep restarts at word 0.
//   - wen during busy does not modify memory.
// - Out of range: DEPTH=12, write addr 13 then read addr 13 -> doutb=0, vld=1; words 0..11 untouched.

Source files
------------

// File: rtl/core_mem_pkg.sv
// core_mem_pkg
// Shared definitions for the memory primitives of the core:
//   - clog2: ceil(log2(value)), never less than 1, used to size address ports
//   - FWD_READ_OLD / FWD_WRITE_FIRST: read-during-write collision modes
//   - clr_state_e: states of the post-reset clear sequencer
package core_mem_pkg;

  localparam int FWD_READ_OLD    = 0;
  localparam int FWD_WRITE_FIRST = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } clr_state_e;

  // A one-bit minimum keeps address ports legal for tiny memories.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dpram_clr_seq.sv
// dpram_clr_seq
// Post-reset clear sequencer for dpram_be. After reset it writes zero to
// every word, one word per cycle from address 0 up to DEPTH-1, and then
// reports the memory as ready.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; restarts the sweep at word 0
//   clr_wen   out  write strobe for the clear write of this cycle
//   clr_addr  out  address being cleared this cycle
//   init_busy out  high until the sweep has written the last word
module dpram_clr_seq
  import core_mem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int INIT_CLR = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    clr_wen,
  output logic [clog2(DEPTH)-1:0] clr_addr,
  output logic                    init_busy
);

  localparam int              AW   = clog2(DEPTH);
  localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Reset lands directly in CLEAR so the sweep starts on the first edge
  // after reset is released; without a sweep the memory is ready at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLR != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_wen = 1'b0;
    case (state_q)
      IDLE:  state_d = IDLE;
      CLEAR: begin
        clr_wen = 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: state_d = READY;
      default: state_d = state_q;
    endcase
  end

  assign clr_addr  = cnt_q;
  assign init_busy = (state_q != READY);

endmodule

// File: rtl/dpram_be.sv
// dpram_be
// Simple dual-port RAM: port A writes with byte enables, port B reads with a
// latency of 1 or 2 cycles. Optional write-first forwarding on same-address
// collisions and an optional zeroing sweep after reset.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   init_busy  out  clear sweep running; all requests are ignored
//   wen        in   port A write strobe
//   wbe        in   byte enables, bit i covers dina[8i+7:8i]
//   addra      in   write address
//   dina       in   write data
//   ren        in   port B read strobe
//   addrb      in   read address
//   doutb      out  read data, held until the next accepted read completes
//   doutb_vld  out  one-cycle pulse when doutb carries a new read result
module dpram_be
  import core_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 1,
  parameter int FWD_MODE = FWD_READ_OLD,
  parameter int INIT_CLR = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wen,
  input  logic [WIDTH/8-1:0]      wbe,
  input  logic [clog2(DEPTH)-1:0] addra,
  input  logic [WIDTH-1:0]        dina,
  input  logic                    ren,
  input  logic [clog2(DEPTH)-1:0] addrb,
  output logic [WIDTH-1:0]        doutb,
  output logic                    doutb_vld
);

  localparam int            AW      = clog2(DEPTH);
  localparam int            NB      = WIDTH / 8;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_err_width
    $error("dpram_be: WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_err_lat
    $error("dpram_be: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_err_depth
    $error("dpram_be: DEPTH must be at least 2");
  end

  logic             clr_wen;
  logic [AW-1:0]    clr_addr;
  logic             accept;
  logic             wr_in_range, rd_in_range;
  logic             user_wr, user_rd;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [NB-1:0]    wr_be;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_word;
  logic             stage_vld;
  logic [WIDTH-1:0] stage_data;
  logic [WIDTH-1:0] doutb_q, doutb_d;
  logic             vld_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  dpram_clr_seq #(
    .DEPTH    (DEPTH),
    .INIT_CLR (INIT_CLR)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_wen   (clr_wen),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign accept      = ~init_busy & ~rst;
  assign wr_in_range = ({1'b0, addra} < DEPTH_W);
  assign rd_in_range = ({1'b0, addrb} < DEPTH_W);
  assign user_wr     = accept & wen & wr_in_range;
  assign user_rd     = accept & ren;

  // The clear sweep owns the write port while it runs.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addra;
    wr_be   = wbe;
    wr_data = dina;
    if (clr_wen) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_be   = '1;
      wr_data = '0;
    end else if (user_wr) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Array read sees the pre-write word; write-first mode patches in the
  // enabled bytes of a same-edge write to the same address.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[addrb];
      if (FWD_MODE == FWD_WRITE_FIRST && user_wr && addra == addrb) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe[i]) begin
            rd_word[8*i +: 8] = dina[8*i +: 8];
          end
        end
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             s1_vld_q;
    logic [WIDTH-1:0] s1_data_q;

    // The captured word is final; later writes do not reach it.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_vld_q  <= 1'b0;
        s1_data_q <= '0;
      end else begin
        s1_vld_q <= user_rd;
        if (user_rd) begin
          s1_data_q <= rd_word;
        end
      end
    end

    assign stage_vld  = s1_vld_q;
    assign stage_data = s1_data_q;
  end else begin : g_lat1
    assign stage_vld  = user_rd;
    assign stage_data = rd_word;
  end

  assign doutb_d = stage_vld ? stage_data : doutb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      doutb_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      doutb_q <= doutb_d;
      vld_q   <= stage_vld;
    end
  end

  assign doutb     = doutb_q;
  assign doutb_vld = vld_q;

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be
// Drives two dpram_be instances from the same stimulus:
//   dut0: DEPTH=12, RD_LAT=2, write-first collisions
//   dut1: DEPTH=16, RD_LAT=1, read-old collisions
// A behavioural model (word arrays plus a schedule of read results keyed by
// completion cycle) predicts busy, valid and data every cycle.
module tb_dpram_be;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [3:0]  wbe;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic        ren;
  logic [3:0]  addrb;
  logic        busy0, busy1;
  logic [31:0] dout0, dout1;
  logic        vld0, vld1;

  int nChecks = 0;
  int nFails  = 0;

  dpram_be #(
    .WIDTH(32), .DEPTH(12), .RD_LAT(2), .FWD_MODE(1), .INIT_CLR(1)
  ) dut0 (
    .clk(clk), .rst(rst), .init_busy(busy0),
    .wen(wen), .wbe(wbe), .addra(addra), .dina(dina),
    .ren(ren), .addrb(addrb), .doutb(dout0), .doutb_vld(vld0)
  );

  dpram_be #(
    .WIDTH(32), .DEPTH(16), .RD_LAT(1), .FWD_MODE(0), .INIT_CLR(1)
  ) dut1 (
    .clk(clk), .rst(rst), .init_busy(busy1),
    .wen(wen), .wbe(wbe), .addra(addra), .dina(dina),
    .ren(ren), .addrb(addrb), .doutb(dout1), .doutb_vld(vld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model
  function automatic int depthOf(input int k);
    return (k == 0) ? 12 : 16;
  endfunction

  function automatic int latOf(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit fwdOf(input int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                             input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = newW[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0] mMem [2][16];
  int          busyLeft [2];
  logic [31:0] expDout [2];
  logic        expVld [2];
  logic [31:0] sched [longint];
  longint      cyc = 0;
  bit          started = 0;

  always @(posedge clk) begin
    logic [31:0] val;
    longint key;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busyLeft[k] = depthOf(k);
        expVld[k]   = 1'b0;
        expDout[k]  = 32'h0;
        started     = 1;
      end else if (busyLeft[k] > 0) begin
        busyLeft[k]--;
        if (busyLeft[k] == 0) begin
          for (int a = 0; a < 16; a++) mMem[k][a] = 32'h0;
        end
        expVld[k] = 1'b0;
      end else begin
        if (ren) begin
          val = (int'(addrb) < depthOf(k)) ? mMem[k][addrb] : 32'h0;
          if (fwdOf(k) && wen && addra == addrb && int'(addrb) < depthOf(k))
            val = mergeBytes(val, dina, wbe);
          sched[(cyc + longint'(latOf(k)) - 1) * 2 + longint'(k)] = val;
        end
        if (wen && int'(addra) < depthOf(k))
          mMem[k][addra] = mergeBytes(mMem[k][addra], dina, wbe);
        key = cyc * 2 + longint'(k);
        if (sched.exists(key)) begin
          expVld[k]  = 1'b1;
          expDout[k] = sched[key];
          sched.delete(key);
        end else begin
          expVld[k] = 1'b0;
        end
      end
    end
    if (rst) sched.delete();
    #1;
    if (started) begin
      checkOutput("busy0", 32'(busy0), 32'(busyLeft[0] > 0));
      checkOutput("busy1", 32'(busy1), 32'(busyLeft[1] > 0));
      checkOutput("vld0",  32'(vld0),  32'(expVld[0]));
      checkOutput("vld1",  32'(vld1),  32'(expVld[1]));
      checkOutput("dout0", dout0, expDout[0]);
      checkOutput("dout1", dout1, expDout[1]);
    end
  end

  // Stimulus
  task automatic applyStimulus(input logic w, input logic [3:0] be,
                               input logic [3:0] aa, input logic [31:0] d,
                               input logic r, input logic [3:0] ab);
    @(negedge clk);
    wen = w; wbe = be; addra = aa; dina = d; ren = r; addrb = ab;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  // Called on the negedge where rst was just released; counts busy cycles
  // while poking the write and read ports, which must be ignored.
  task automatic countBusy(input string name);
    int c0, c1;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (busy0) begin
        wen = 1'b1; wbe = 4'hF; addra = 4'(i); dina = $urandom;
        ren = 1'b1; addrb = 4'(i);
      end else begin
        wen = 1'b0; ren = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({name, "Cycles0"}, 32'(c0), 32'd12);
    checkOutput({name, "Cycles1"}, 32'(c1), 32'd16);
  endtask

  task automatic readAll(input int n);
    for (int a = 0; a < n; a++) applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    idle(3);
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; wbe = 4'h0; addra = 4'h0; dina = 32'h0;
    ren = 1'b0; addrb = 4'h0;

    // Reset for two cycles, then the sweep
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    countBusy("sweep");
    readAll(16);
    checkOutput("sweepZero1", dout1, 32'h0);

    // Byte enables
    applyStimulus(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    idle(1);
    @(negedge clk);
    checkOutput("byteEn0", dout0, 32'hAA22CC44);
    checkOutput("byteEnVld0", 32'(vld0), 32'd1);
    checkOutput("byteEn1", dout1, 32'hAA22CC44);

    // Latency: back-to-back reads of 1, 2, 3
    applyStimulus(1'b1, 4'hF, 4'd1, 32'h00000111, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'hF, 4'd2, 32'h00000222, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
    checkOutput("lat1Vld0", 32'(vld0), 32'd0);
    checkOutput("lat1Dout1", dout1, 32'h00000111);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    checkOutput("lat2Vld0", 32'(vld0), 32'd1);
    checkOutput("lat2Dout0", dout0, 32'h00000111);
    idle(1);
    checkOutput("lat3Dout0", dout0, 32'h00000222);
    idle(1);
    checkOutput("lat4Dout0", dout0, 32'hAA22CC44);
    checkOutput("lat4Vld0", 32'(vld0), 32'd1);
    idle(1);
    checkOutput("lat5Vld0", 32'(vld0), 32'd0);

    // Collision at address 5 (still zero from the sweep)
    applyStimulus(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
    idle(1);
    @(negedge clk);
    checkOutput("collideFwd0", dout0, 32'h0000FFFF);
    checkOutput("collideOld1", dout1, 32'h00000000);
    readAll(6);

    // Out-of-range address on the 12-word instance
    applyStimulus(1'b1, 4'hF, 4'd13, 32'hDEADBEEF, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd13);
    idle(1);
    @(negedge clk);
    checkOutput("oorDout0", dout0, 32'h0);
    checkOutput("oorVld0", 32'(vld0), 32'd1);
    checkOutput("oorDout1", dout1, 32'hDEADBEEF);
    readAll(12);

    // Reset while a 2-cycle read is in flight
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    @(negedge clk); ren = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("inflightVld0", 32'(vld0), 32'd0);
    checkOutput("inflightDout0", dout0, 32'h0);
    rst = 1'b0;
    countBusy("afterInflight");

    // Reset while the sweep is at word 7
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    countBusy("midSweep");
    readAll(16);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic [3:0] aa;
      aa = 4'($urandom_range(0, 15));
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      wen   = 1'($urandom_range(0, 1));
      wbe   = 4'($urandom);
      addra = aa;
      dina  = $urandom;
      ren   = 1'($urandom_range(0, 1));
      addrb = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
    end
    @(negedge clk); rst = 1'b0;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
